// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and types for the up/down BCD counter.
package bcd_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with wrap-around increment/decrement and parallel load.
// Latency 1 cycle; no backpressure, acts on every enabled edge.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_min
);
    bcd_digit_t q_q;
    bcd_digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
        end else if (dec) begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) q_q <= BCD_MIN;
        else       q_q <= q_d;
    end

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);
    assign at_min = (q_q == BCD_MIN);
endmodule

// File: rtl/bcd_updown_counter_sva.sv
// Property checker bound into bcd_updown_counter; checks start once a reset has been sampled.
module bcd_updown_counter_sva
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input logic                clock,
    input logic                reset,
    input logic                enb,
    input logic                up,
    input logic                load,
    input logic [4*DIGITS-1:0] load_val,
    input logic [4*DIGITS-1:0] out,
    input logic                tc,
    input logic                load_err
);
    localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{BCD_MAX}};

    logic seen_q;
    logic load_bad;
    logic wrap;

    always_ff @(posedge clock) begin
        if (reset) seen_q <= 1'b1;
    end

    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_bad = load_bad | ~is_bcd(load_val[4*i +: BCD_W]);
        end
        wrap = ~reset & ~load & enb & (up ? (out == ALL9) : (out == '0));
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_chk
        a_digit_bcd: assert property (@(posedge clock) seen_q |-> out[4*g +: BCD_W] <= BCD_MAX);
    end

    a_up_wrap: assert property (@(posedge clock)
        seen_q && !reset && !load && enb && up && out == ALL9 |=> out == '0 && tc);
    a_dn_wrap: assert property (@(posedge clock)
        seen_q && !reset && !load && enb && !up && out == '0 |=> out == ALL9 && tc);
    a_hold: assert property (@(posedge clock)
        seen_q && !reset && !load && !enb |=> $stable(out) && !tc && !load_err);
    a_tc_pulse: assert property (@(posedge clock)
        seen_q |=> tc == $past(wrap));
    a_err_pulse: assert property (@(posedge clock)
        seen_q |=> load_err == $past(!reset && load && load_bad));
endmodule

bind bcd_updown_counter bcd_updown_counter_sva #(.DIGITS(DIGITS)) u_sva (
    .clock    (clock),
    .reset    (reset),
    .enb      (enb),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .tc       (tc),
    .load_err (load_err)
);

// File: rtl/bcd_updown_counter.sv
// Cascaded DIGITS-wide BCD up/down counter with validated parallel load.
// Latency 1 cycle from sampled inputs to registered outputs; no backpressure.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enb,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] out,
    output logic                tc,
    output logic                load_err
);
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] dec;
    logic              ld;
    logic              load_ok;
    logic              count_en;
    logic              carry;
    logic              borrow;
    logic              tc_q, tc_d;
    logic              load_err_q, load_err_d;

    // A digit steps only when every lower digit is about to wrap.
    always_comb begin
        load_ok  = 1'b1;
        count_en = enb & ~load;
        carry    = 1'b1;
        borrow   = 1'b1;
        inc      = '0;
        dec      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_ok = load_ok & is_bcd(load_val[4*i +: BCD_W]);
            inc[i]  = count_en & up & carry;
            dec[i]  = count_en & ~up & borrow;
            carry   = carry & at_max[i];
            borrow  = borrow & at_min[i];
        end
        ld         = load & load_ok;
        tc_d       = count_en & (up ? carry : borrow);
        load_err_d = load & ~load_ok;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock  (clock),
            .reset  (reset),
            .inc    (inc[g]),
            .dec    (dec[g]),
            .ld     (ld),
            .ld_val (load_val[4*g +: BCD_W]),
            .q      (out[4*g +: BCD_W]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = tc_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized + directed scoreboard bench for a 2-digit bcd_updown_counter.
module tb_bcd_updown_counter;
    localparam int D    = 2;
    localparam int W    = 4 * D;
    localparam int MAXV = 99;

    typedef struct packed {
        logic [W-1:0] out;
        logic         tc;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enb = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         tc;
    logic         load_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt = 0;

    bcd_updown_counter #(.DIGITS(D)) dut (
        .clock    (clk),
        .reset    (reset),
        .enb      (enb),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'(v / 10);
        return r;
    endfunction

    // Reference behaviour: count kept as a plain integer, converted to BCD for comparison.
    task automatic step(input logic r, input logic e, input logic u,
                        input logic l, input logic [W-1:0] lv);
        exp_t x;
        logic [3:0] lo, hi;
        @(negedge clk);
        reset = r; enb = e; up = u; load = l; load_val = lv;
        lo = lv[3:0];
        hi = lv[7:4];
        x.tc  = 1'b0;
        x.err = 1'b0;
        if (r) begin
            model_cnt = 0;
        end else if (l) begin
            if (lo <= 4'd9 && hi <= 4'd9) model_cnt = int'(hi) * 10 + int'(lo);
            else x.err = 1'b1;
        end else if (e) begin
            if (u) begin
                x.tc = (model_cnt == MAXV);
                model_cnt = (model_cnt + 1) % (MAXV + 1);
            end else begin
                x.tc = (model_cnt == 0);
                model_cnt = (model_cnt == 0) ? MAXV : model_cnt - 1;
            end
        end
        x.out = to_bcd(model_cnt);
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (out !== e.out) begin
                n_bad++;
                $display("FAIL out: got %h expected %h (t=%0t)", out, e.out, $time);
            end
            n_cmp++;
            if (tc !== e.tc) begin
                n_bad++;
                $display("FAIL tc: got %b expected %b out=%h (t=%0t)", tc, e.tc, out, $time);
            end
            n_cmp++;
            if (load_err !== e.err) begin
                n_bad++;
                $display("FAIL load_err: got %b expected %b (t=%0t)", load_err, e.err, $time);
            end
        end
    end

    initial begin
        logic [W-1:0] lv;
        int drain;
        repeat (2) @(negedge clk);

        step(1, 1, 1, 1, 8'h77);
        repeat (100) step(0, 1, 1, 0, '0);

        step(0, 0, 1, 1, 8'h05);
        repeat (7) step(0, 1, 0, 0, '0);

        step(0, 0, 0, 1, 8'h42);
        step(0, 1, 1, 1, 8'h3A);
        step(0, 0, 1, 0, '0);

        step(0, 1, 1, 1, 8'h19);
        step(0, 1, 1, 0, '0);

        step(0, 0, 1, 1, 8'h57);
        step(1, 1, 1, 1, 8'h99);
        step(0, 0, 1, 0, '0);

        step(0, 0, 1, 1, 8'h09);
        for (int i = 0; i < 4; i++) step(0, 1, (i % 2) == 0, 0, '0);

        step(0, 1, 0, 0, '0);
        step(0, 1, 1, 0, '0);
        step(0, 1, 1, 1, 8'hA0);
        step(0, 1, 1, 1, 8'h0F);

        for (int i = 0; i < 600; i++) begin
            lv[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            lv[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) != 0) begin
                lv[3:0] = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'd0;
                lv[7:4] = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'd0;
                if ($urandom_range(0, 1) == 1) lv = ($urandom_range(0, 1) == 1) ? 8'h98 : 8'h01;
            end
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, lv);
        end

        @(negedge clk);
        enb = 1'b0; load = 1'b0; reset = 1'b0;
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
